// File: rtl/tb_axi_pkg.sv
// Shared types for the AXI handshake stall injector: channel and mode encodings
// plus the Galois LFSR feedback mask.
package tb_axi_pkg;

  localparam int N_CHAN = 5;

  typedef enum logic [2:0] {AW, W, B, AR, R} chan_e;

  typedef enum logic [1:0] {PASS, RANDOM, BURST, FREEZE} mode_e;

  // Right-shifting Galois mask for x^16 + x^14 + x^13 + x^11 + 1.
  localparam logic [15:0] LFSR_TAP = 16'hB400;

endpackage

// File: rtl/stall_gate.sv
// Single-channel valid/ready throttle: decides per cycle whether a new valid may
// pass downstream, and holds any presented valid until the sink accepts it.
module stall_gate
  import tb_axi_pkg::*;
#(
  parameter int                LFSR_W = 16,
  parameter logic [LFSR_W-1:0] SEED   = 16'hACE1,
  parameter int                PROB_W = 11,
  parameter int                CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [1:0]        cfg_mode,
  input  logic [PROB_W-1:0] cfg_prob,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic [CNT_W-1:0]  cfg_stall_len,
  input  logic [CNT_W-1:0]  cfg_max_stall,
  input  logic              src_valid,
  output logic              src_ready,
  output logic              dst_valid,
  input  logic              dst_ready,
  output logic [31:0]       stall_cnt
);

  localparam logic [LFSR_W-1:0] TAP = LFSR_W'(LFSR_TAP);

  // Handshake: dst_valid is asserted only for a valid source, and once asserted
  // it stays asserted (held) until dst_valid & dst_ready; src_ready mirrors that
  // transfer so the source never sees ready without an accepted beat.
  mode_e             mode;
  mode_e             mode_q;
  logic [LFSR_W-1:0] lfsr;
  logic [CNT_W-1:0]  phase;
  logic [CNT_W-1:0]  phase_eff;
  logic [CNT_W-1:0]  stall_run;
  logic              held;
  logic              gate_open;
  logic              capped;
  logic              open;
  logic              transfer;

  assign mode = mode_e'(cfg_mode);

  // A mode change restarts the burst phase in the very cycle it takes effect.
  assign phase_eff = (mode != mode_q) ? '0 : phase;
  assign capped    = (cfg_max_stall != '0) && (stall_run >= cfg_max_stall);

  always_comb begin
    gate_open = 1'b1;
    case (mode)
      PASS:    gate_open = 1'b1;
      RANDOM:  gate_open = (PROB_W'(lfsr[9:0]) < cfg_prob);
      BURST:   gate_open = (cfg_period == '0) || (phase_eff >= cfg_stall_len);
      FREEZE:  gate_open = 1'b0;
      default: gate_open = 1'b1;
    endcase
  end

  assign open      = gate_open | (capped & (mode != FREEZE));
  assign dst_valid = rstn & src_valid & (open | held);
  assign transfer  = dst_valid & dst_ready;
  assign src_ready = transfer;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lfsr      <= SEED;
      mode_q    <= PASS;
      phase     <= '0;
      held      <= 1'b0;
      stall_run <= '0;
      stall_cnt <= '0;
    end else begin
      lfsr   <= lfsr[0] ? ((lfsr >> 1) ^ TAP) : (lfsr >> 1);
      mode_q <= mode;

      if ((cfg_period == '0) || (phase_eff >= cfg_period - 1'b1))
        phase <= '0;
      else
        phase <= phase_eff + 1'b1;

      if (transfer)
        held <= 1'b0;
      else if (dst_valid)
        held <= 1'b1;

      if (src_valid & ~open & ~held) begin
        if (stall_run != '1)
          stall_run <= stall_run + 1'b1;
      end else begin
        stall_run <= '0;
      end

      if (src_valid & ~transfer & ~(&stall_cnt))
        stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/axi_stall_injector.sv
// AXI handshake throttle for M_COUNT ports x 5 channels (AW, W, B, AR, R);
// each channel gets an independent stall_gate with its own LFSR seed.
module axi_stall_injector
  import tb_axi_pkg::*;
#(
  parameter int                M_COUNT = 1,
  parameter int                LFSR_W  = 16,
  parameter logic [LFSR_W-1:0] SEED    = 16'hACE1,
  parameter int                PROB_W  = 11,
  parameter int                CNT_W   = 16
) (
  input  logic                                        clk,
  input  logic                                        rstn,
  input  logic [M_COUNT-1:0][N_CHAN-1:0][1:0]         cfg_mode,
  input  logic [M_COUNT-1:0][N_CHAN-1:0][PROB_W-1:0]  cfg_prob,
  input  logic [M_COUNT-1:0][N_CHAN-1:0][CNT_W-1:0]   cfg_period,
  input  logic [M_COUNT-1:0][N_CHAN-1:0][CNT_W-1:0]   cfg_stall_len,
  input  logic [M_COUNT-1:0][N_CHAN-1:0][CNT_W-1:0]   cfg_max_stall,
  input  logic [M_COUNT-1:0][N_CHAN-1:0]              src_valid,
  output logic [M_COUNT-1:0][N_CHAN-1:0]              src_ready,
  output logic [M_COUNT-1:0][N_CHAN-1:0]              dst_valid,
  input  logic [M_COUNT-1:0][N_CHAN-1:0]              dst_ready,
  output logic [M_COUNT-1:0][N_CHAN-1:0][31:0]        stall_cnt
);

  for (genvar m = 0; m < M_COUNT; m++) begin : g_port
    for (genvar c = 0; c < N_CHAN; c++) begin : g_chan
      // An all-zero state would lock the LFSR, so that one seed is replaced.
      localparam logic [LFSR_W-1:0] RAW_SEED = SEED ^ LFSR_W'(m * N_CHAN + c + 1);
      localparam logic [LFSR_W-1:0] CH_SEED  = (RAW_SEED == '0) ? LFSR_W'(1) : RAW_SEED;

      stall_gate #(
        .LFSR_W (LFSR_W),
        .SEED   (CH_SEED),
        .PROB_W (PROB_W),
        .CNT_W  (CNT_W)
      ) u_gate (
        .clk           (clk),
        .rstn          (rstn),
        .cfg_mode      (cfg_mode[m][c]),
        .cfg_prob      (cfg_prob[m][c]),
        .cfg_period    (cfg_period[m][c]),
        .cfg_stall_len (cfg_stall_len[m][c]),
        .cfg_max_stall (cfg_max_stall[m][c]),
        .src_valid     (src_valid[m][c]),
        .src_ready     (src_ready[m][c]),
        .dst_valid     (dst_valid[m][c]),
        .dst_ready     (dst_ready[m][c]),
        .stall_cnt     (stall_cnt[m][c])
      );
    end
  end

endmodule

// File: tb/tb_axi_stall_injector.sv
// Directed bench for axi_stall_injector with two ports (ten channels) driven
// identically; expected values are hand-derived or from a small LFSR model.
module tb_axi_stall_injector;

  localparam int M   = 2;
  localparam int NC  = 5;
  localparam int NCH = M * NC;

  logic                      clk;
  logic                      rstn;
  logic [M-1:0][NC-1:0][1:0]  cfg_mode;
  logic [M-1:0][NC-1:0][10:0] cfg_prob;
  logic [M-1:0][NC-1:0][15:0] cfg_period;
  logic [M-1:0][NC-1:0][15:0] cfg_stall_len;
  logic [M-1:0][NC-1:0][15:0] cfg_max_stall;
  logic [M-1:0][NC-1:0]       src_valid;
  logic [M-1:0][NC-1:0]       src_ready;
  logic [M-1:0][NC-1:0]       dst_valid;
  logic [M-1:0][NC-1:0]       dst_ready;
  logic [M-1:0][NC-1:0][31:0] stall_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  logic [NCH-1:0] exp_q[$];

  axi_stall_injector #(.M_COUNT(M)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .cfg_mode      (cfg_mode),
    .cfg_prob      (cfg_prob),
    .cfg_period    (cfg_period),
    .cfg_stall_len (cfg_stall_len),
    .cfg_max_stall (cfg_max_stall),
    .src_valid     (src_valid),
    .src_ready     (src_ready),
    .dst_valid     (dst_valid),
    .dst_ready     (dst_ready),
    .stall_cnt     (stall_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  // ---------------- drivers ----------------
  task automatic set_cfg(input logic [1:0] mode, input logic [10:0] prob,
                         input logic [15:0] period, input logic [15:0] slen,
                         input logic [15:0] maxs);
    for (int m = 0; m < M; m++)
      for (int c = 0; c < NC; c++) begin
        cfg_mode[m][c]      = mode;
        cfg_prob[m][c]      = prob;
        cfg_period[m][c]    = period;
        cfg_stall_len[m][c] = slen;
        cfg_max_stall[m][c] = maxs;
      end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    set_cfg(2'd0, 11'd0, 16'd0, 16'd0, 16'd0);
    src_valid = '1;
    dst_ready = '1;
    rstn = 1'b0;
    @(negedge clk);
    n_checks++;
    if (dst_valid !== '0) $display("FAIL reset_dst_valid got=%h exp=0", dst_valid);
    else n_pass++;
    n_checks++;
    if (src_ready !== '0) $display("FAIL reset_src_ready got=%h exp=0", src_ready);
    else n_pass++;
    n_checks++;
    if (stall_cnt !== '0) $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt[0][0]);
    else n_pass++;
    @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic test_pass();
    int cnt[NCH];
    int gaps;
    logic [NCH-1:0] dv, sr;
    gaps = 0;
    for (int ch = 0; ch < NCH; ch++) cnt[ch] = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      dv = dst_valid;
      sr = src_ready;
      if (dv !== '1 || sr !== '1) gaps++;
      for (int ch = 0; ch < NCH; ch++) cnt[ch] += int'(dv[ch] & sr[ch]);
    end
    n_checks++;
    if (gaps !== 0) $display("FAIL pass_gaps got=%0d exp=0", gaps);
    else n_pass++;
    for (int ch = 0; ch < NCH; ch++) begin
      n_checks++;
      if (cnt[ch] !== 100) $display("FAIL pass_xfers ch=%0d got=%0d exp=100", ch, cnt[ch]);
      else n_pass++;
    end
    n_checks++;
    if (stall_cnt !== '0) $display("FAIL pass_stall_cnt got=%0d exp=0", stall_cnt[0][0]);
    else n_pass++;
  endtask

  task automatic test_burst();
    int cnt[NCH];
    int bad;
    logic [NCH-1:0] dv, exp_dv;
    bad = 0;
    for (int ch = 0; ch < NCH; ch++) cnt[ch] = 0;
    set_cfg(2'd2, 11'd0, 16'd10, 16'd4, 16'd0);
    src_valid = '1;
    dst_ready = '1;
    do_reset();
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      dv = dst_valid;
      exp_dv = ((k % 10) >= 4) ? '1 : '0;
      if (dv !== exp_dv) bad++;
      for (int ch = 0; ch < NCH; ch++) cnt[ch] += int'(dv[ch]);
    end
    n_checks++;
    if (bad !== 0) $display("FAIL burst_pattern bad_cycles=%0d exp=0", bad);
    else n_pass++;
    for (int ch = 0; ch < NCH; ch++) begin
      n_checks++;
      if (cnt[ch] !== 60) $display("FAIL burst_xfers ch=%0d got=%0d exp=60", ch, cnt[ch]);
      else n_pass++;
    end
    @(negedge clk);
    n_checks++;
    if (stall_cnt[0][0] !== 32'd40 || stall_cnt[1][4] !== 32'd40)
      $display("FAIL burst_stall_cnt got=%0d/%0d exp=40", stall_cnt[0][0], stall_cnt[1][4]);
    else n_pass++;
  endtask

  task automatic test_random();
    int cnt[NCH];
    int model_bad, trace_bad;
    logic [15:0] s0, s9;
    logic [NCH-1:0] dv, exp_dv;
    model_bad = 0;
    trace_bad = 0;
    s0 = 16'hACE1 ^ 16'd1;
    s9 = 16'hACE1 ^ 16'd10;
    for (int ch = 0; ch < NCH; ch++) cnt[ch] = 0;
    set_cfg(2'd1, 11'd512, 16'd0, 16'd0, 16'd0);
    src_valid = '1;
    dst_ready = '1;
    do_reset();
    for (int k = 0; k < 10000; k++) begin
      @(negedge clk);
      dv = dst_valid;
      exp_q.push_back(dv);
      for (int ch = 0; ch < NCH; ch++) cnt[ch] += int'(dv[ch]);
      if (k < 200) begin
        if (dv[0] !== (s0[9:0] < 10'd512)) model_bad++;
        if (dv[9] !== (s9[9:0] < 10'd512)) model_bad++;
        s0 = lfsr_step(s0);
        s9 = lfsr_step(s9);
      end
    end
    for (int ch = 0; ch < NCH; ch++) begin
      n_checks++;
      if (cnt[ch] < 4700 || cnt[ch] > 5300)
        $display("FAIL random_xfers ch=%0d got=%0d exp=4700..5300", ch, cnt[ch]);
      else n_pass++;
    end
    n_checks++;
    if (model_bad !== 0) $display("FAIL random_lfsr_model bad=%0d exp=0", model_bad);
    else n_pass++;
    // Rerun from a fresh reset; the trace must repeat exactly.
    do_reset();
    for (int k = 0; k < 10000; k++) begin
      @(negedge clk);
      exp_dv = exp_q.pop_front();
      if (dst_valid !== exp_dv) trace_bad++;
    end
    n_checks++;
    if (trace_bad !== 0 || exp_q.size() !== 0)
      $display("FAIL random_rerun bad=%0d left=%0d exp=0/0", trace_bad, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_hold();
    int bad;
    logic [NCH-1:0] exp_dv;
    bad = 0;
    set_cfg(2'd1, 11'd0, 16'd0, 16'd0, 16'd3);
    src_valid = '1;
    dst_ready = '0;
    do_reset();
    for (int k = 0; k < 23; k++) begin
      @(negedge clk);
      exp_dv = (k >= 3) ? '1 : '0;
      if (dst_valid !== exp_dv || src_ready !== '0) bad++;
    end
    n_checks++;
    if (bad !== 0) $display("FAIL hold_pattern bad_cycles=%0d exp=0", bad);
    else n_pass++;
    @(posedge clk);
    #1 dst_ready = '1;
    @(negedge clk);
    n_checks++;
    if (dst_valid !== '1 || src_ready !== '1)
      $display("FAIL hold_transfer got=%h/%h exp=3ff/3ff", dst_valid, src_ready);
    else n_pass++;
    n_checks++;
    if (stall_cnt[0][0] !== 32'd23 || stall_cnt[1][4] !== 32'd23)
      $display("FAIL hold_stall_cnt got=%0d/%0d exp=23", stall_cnt[0][0], stall_cnt[1][4]);
    else n_pass++;
    @(posedge clk);
    #1 dst_ready = '0;
    @(negedge clk);
    n_checks++;
    if (dst_valid !== '0) $display("FAIL hold_cleared got=%h exp=0", dst_valid);
    else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++;
    if (dst_valid !== '1) $display("FAIL hold_cap_reopen got=%h exp=3ff", dst_valid);
    else n_pass++;
  endtask

  task automatic test_freeze();
    int bad;
    bad = 0;
    set_cfg(2'd0, 11'd0, 16'd0, 16'd0, 16'd3);
    src_valid = '1;
    dst_ready = '0;
    do_reset();
    @(negedge clk);
    n_checks++;
    if (dst_valid !== '1) $display("FAIL freeze_initial_valid got=%h exp=3ff", dst_valid);
    else n_pass++;
    @(posedge clk);
    #1 set_cfg(2'd3, 11'd0, 16'd0, 16'd0, 16'd3);
    @(negedge clk);
    n_checks++;
    if (dst_valid !== '1) $display("FAIL freeze_held_valid got=%h exp=3ff", dst_valid);
    else n_pass++;
    @(posedge clk);
    #1 dst_ready = '1;
    @(negedge clk);
    n_checks++;
    if (src_ready !== '1) $display("FAIL freeze_held_xfer got=%h exp=3ff", src_ready);
    else n_pass++;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (dst_valid !== '0 || src_ready !== '0) bad++;
    end
    n_checks++;
    if (bad !== 0) $display("FAIL freeze_closed bad_cycles=%0d exp=0", bad);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (stall_cnt[0][0] !== 32'd52 || stall_cnt[1][4] !== 32'd52)
      $display("FAIL freeze_stall_cnt got=%0d/%0d exp=52", stall_cnt[0][0], stall_cnt[1][4]);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int bad;
    logic [15:0] s0;
    bad = 0;
    s0 = 16'hACE1 ^ 16'd1;
    set_cfg(2'd2, 11'd0, 16'd10, 16'd4, 16'd0);
    src_valid = '1;
    dst_ready = '0;
    do_reset();
    repeat (6) @(negedge clk);
    n_checks++;
    if (dst_valid !== '1 || stall_cnt[0][0] !== 32'd5)
      $display("FAIL mid_held_before got=%h/%0d exp=3ff/5", dst_valid, stall_cnt[0][0]);
    else n_pass++;
    #2 rstn = 1'b0;
    #1;
    n_checks++;
    if (dst_valid !== '0 || src_ready !== '0)
      $display("FAIL mid_async_drop got=%h/%h exp=0/0", dst_valid, src_ready);
    else n_pass++;
    n_checks++;
    if (stall_cnt !== '0) $display("FAIL mid_stall_cnt got=%0d exp=0", stall_cnt[0][0]);
    else n_pass++;
    set_cfg(2'd1, 11'd512, 16'd0, 16'd0, 16'd0);
    dst_ready = '1;
    @(posedge clk);
    #1 rstn = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (dst_valid[0][0] !== (s0[9:0] < 10'd512)) bad++;
      s0 = lfsr_step(s0);
    end
    n_checks++;
    if (bad !== 0) $display("FAIL mid_lfsr_restart bad=%0d exp=0", bad);
    else n_pass++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rstn = 1'b0;
    test_reset();
    test_pass();
    test_burst();
    test_random();
    test_hold();
    test_freeze();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
